// File: rtl/alarm_display_ctrl.sv
// Alarm display controller: arming sequence, frame-based motion detection,
// held alarm display with acknowledge/disarm exit, and a strobe-aligned
// overlay select.
//
// state     | meaning
// ----------+------------------------------------------------------------
// DISARMED  | idle, waiting for an arm request
// ARMING    | exit delay, counting frame strobes before arming
// ARMED     | watching for consecutive motion frames
// TRIGGERED | alarm shown, held for a minimum number of frames
module alarm_display_ctrl #(
  parameter int ARM_DELAY_FRAMES = 300,
  parameter int DETECT_FRAMES    = 3,
  parameter int HOLD_FRAMES      = 600
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iFrame_Strobe,
  input  logic       iArm,
  input  logic       iMotion,
  input  logic       iAck,
  output logic       oVideo_On,
  output logic [1:0] oState,
  output logic       oAlarm_Pulse,
  output logic       oHold_Done
);

  typedef enum logic [1:0] {
    ST_DISARMED  = 2'd0,
    ST_ARMING    = 2'd1,
    ST_ARMED     = 2'd2,
    ST_TRIGGERED = 2'd3
  } state_t;

  localparam logic [15:0] ARM_LAST    = 16'(ARM_DELAY_FRAMES - 1);
  localparam logic [15:0] DETECT_LAST = 16'(DETECT_FRAMES - 1);
  localparam logic [15:0] HOLD_MAX    = 16'(HOLD_FRAMES);
  localparam logic [15:0] CNT_MAX     = 16'hFFFF;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_arm_cnt;
  logic [15:0] r_motion_cnt;
  logic [15:0] r_hold_cnt;
  logic        r_motion_latch;
  logic        r_video_on;
  logic        r_alarm_pulse;
  logic        w_sample;
  logic        w_hold_done;

  // Motion seen anywhere in the frame, including on the strobe cycle itself.
  assign w_sample    = r_motion_latch | iMotion;
  assign w_hold_done = (r_state == ST_TRIGGERED) && (r_hold_cnt == HOLD_MAX);

  // State register.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) r_state <= ST_DISARMED;
    else         r_state <= w_next;
  end

  // Next-state decode; disarm always wins over a same-cycle advance.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_DISARMED: begin
        if (iArm) w_next = ST_ARMING;
      end
      ST_ARMING: begin
        if (!iArm)                                     w_next = ST_DISARMED;
        else if (iFrame_Strobe && r_arm_cnt == ARM_LAST) w_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (!iArm) w_next = ST_DISARMED;
        else if (iFrame_Strobe && w_sample && r_motion_cnt == DETECT_LAST)
          w_next = ST_TRIGGERED;
      end
      ST_TRIGGERED: begin
        // Ack/disarm before the hold expires is dropped, not remembered.
        if (w_hold_done && (iAck || !iArm))
          w_next = iArm ? ST_ARMED : ST_DISARMED;
      end
      default: w_next = ST_DISARMED;
    endcase
  end

  // Motion latch: collects motion between strobes, cleared by every strobe.
  always_ff @(posedge iCLK) begin
    if (!iRST_N)            r_motion_latch <= 1'b0;
    else if (iFrame_Strobe) r_motion_latch <= 1'b0;
    else if (iMotion)       r_motion_latch <= 1'b1;
  end

  // Exit-delay counter, live only in ARMING.
  always_ff @(posedge iCLK) begin
    if (!iRST_N || r_state != ST_ARMING)
      r_arm_cnt <= '0;
    else if (iFrame_Strobe && r_arm_cnt != CNT_MAX)
      r_arm_cnt <= r_arm_cnt + 16'd1;
  end

  // Consecutive-motion-frame counter, live only in ARMED.
  always_ff @(posedge iCLK) begin
    if (!iRST_N || r_state != ST_ARMED)
      r_motion_cnt <= '0;
    else if (iFrame_Strobe) begin
      if (!w_sample)                  r_motion_cnt <= '0;
      else if (r_motion_cnt != CNT_MAX) r_motion_cnt <= r_motion_cnt + 16'd1;
    end
  end

  // Hold counter, saturating at HOLD_FRAMES while TRIGGERED.
  always_ff @(posedge iCLK) begin
    if (!iRST_N || r_state != ST_TRIGGERED)
      r_hold_cnt <= '0;
    else if (iFrame_Strobe && r_hold_cnt != HOLD_MAX)
      r_hold_cnt <= r_hold_cnt + 16'd1;
  end

  // Overlay select only moves on frame boundaries so the picture never tears.
  always_ff @(posedge iCLK) begin
    if (!iRST_N)            r_video_on <= 1'b0;
    else if (iFrame_Strobe) r_video_on <= (w_next == ST_TRIGGERED);
  end

  // Single-cycle alarm pulse aligned with the first TRIGGERED cycle.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) r_alarm_pulse <= 1'b0;
    else         r_alarm_pulse <= (w_next == ST_TRIGGERED) && (r_state != ST_TRIGGERED);
  end

  assign oVideo_On    = r_video_on;
  assign oState       = r_state;
  assign oAlarm_Pulse = r_alarm_pulse;
  assign oHold_Done   = w_hold_done;

endmodule

// File: tb/tb_alarm_display_ctrl.sv
// Directed bench for alarm_display_ctrl with short frame parameters.
module tb_alarm_display_ctrl;

  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic       iFrame_Strobe;
  logic       iArm;
  logic       iMotion;
  logic       iAck;
  logic       oVideo_On;
  logic [1:0] oState;
  logic       oAlarm_Pulse;
  logic       oHold_Done;

  int n_checks = 0;
  int n_errors = 0;

  alarm_display_ctrl #(
    .ARM_DELAY_FRAMES(2),
    .DETECT_FRAMES   (3),
    .HOLD_FRAMES     (4)
  ) dut (
    .iCLK         (iCLK),
    .iRST_N       (iRST_N),
    .iFrame_Strobe(iFrame_Strobe),
    .iArm         (iArm),
    .iMotion      (iMotion),
    .iAck         (iAck),
    .oVideo_On    (oVideo_On),
    .oState       (oState),
    .oAlarm_Pulse (oAlarm_Pulse),
    .oHold_Done   (oHold_Done)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Apply one cycle of pulse inputs, then sample 1ns after the edge.
  task automatic step(input logic strb, input logic mot, input logic ack);
    iFrame_Strobe = strb;
    iMotion       = mot;
    iAck          = ack;
    @(posedge iCLK);
    #1;
    iFrame_Strobe = 1'b0;
    iMotion       = 1'b0;
    iAck          = 1'b0;
  endtask

  // One frame: a couple of idle cycles then the strobe.
  task automatic frame(input logic mot);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, mot, 1'b0);
  endtask

  // DISARMED -> ARMING -> ARMED with a 2-frame exit delay.
  task automatic arm_up();
    iArm = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    frame(1'b0);
    frame(1'b0);
  endtask

  initial begin
    iRST_N = 1'b0; iFrame_Strobe = 1'b0; iArm = 1'b0; iMotion = 1'b0; iAck = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("rst_state", 16'(oState), 16'd0);
    chk("rst_video", 16'(oVideo_On), 16'd0);
    chk("rst_pulse", 16'(oAlarm_Pulse), 16'd0);
    chk("rst_hold",  16'(oHold_Done), 16'd0);
    iRST_N = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("idle_state", 16'(oState), 16'd0);

    // Arm sequence
    iArm = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("arming", 16'(oState), 16'd1);
    frame(1'b0);
    chk("arming_f1", 16'(oState), 16'd1);
    frame(1'b0);
    chk("armed", 16'(oState), 16'd2);
    chk("armed_video", 16'(oVideo_On), 16'd0);

    // Ack outside TRIGGERED has no effect
    step(1'b0, 1'b0, 1'b1);
    chk("ack_armed", 16'(oState), 16'd2);

    // Broken motion run: 1,2, gap, then restart
    step(1'b0, 1'b1, 1'b0);          // latched mid-frame
    step(1'b1, 1'b0, 1'b0);          // frame 1 sampled via latch
    frame(1'b1);                     // frame 2, motion on strobe cycle
    frame(1'b0);                     // gap clears run
    chk("gap_no_trig", 16'(oState), 16'd2);
    frame(1'b1);
    frame(1'b1);
    chk("two_no_trig", 16'(oState), 16'd2);
    chk("two_video", 16'(oVideo_On), 16'd0);
    frame(1'b1);
    chk("trig_state", 16'(oState), 16'd3);
    chk("trig_video", 16'(oVideo_On), 16'd1);
    chk("trig_pulse", 16'(oAlarm_Pulse), 16'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("pulse_once", 16'(oAlarm_Pulse), 16'd0);

    // Hold: early ack ignored, later ack honoured
    frame(1'b0);
    frame(1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("early_ack", 16'(oState), 16'd3);
    chk("early_hold", 16'(oHold_Done), 16'd0);
    frame(1'b0);
    chk("hold3", 16'(oHold_Done), 16'd0);
    frame(1'b0);
    chk("hold4_done", 16'(oHold_Done), 16'd1);
    chk("hold4_state", 16'(oState), 16'd3);
    step(1'b0, 1'b0, 1'b0);
    chk("no_ack_stay", 16'(oState), 16'd3);
    step(1'b0, 1'b0, 1'b1);
    chk("ack_exit", 16'(oState), 16'd2);
    chk("ack_video_hold", 16'(oVideo_On), 16'd1);
    chk("ack_holddone_clr", 16'(oHold_Done), 16'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("video_drop", 16'(oVideo_On), 16'd0);
    chk("rearmed", 16'(oState), 16'd2);

    // Disarm from ARMED and from ARMING
    iArm = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk("disarm_armed", 16'(oState), 16'd0);
    iArm = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    frame(1'b0);
    iArm = 1'b0;
    step(1'b1, 1'b0, 1'b0);          // strobe that would complete arming
    chk("disarm_arming", 16'(oState), 16'd0);

    // Disarm during TRIGGERED waits for hold
    arm_up();
    frame(1'b1);
    frame(1'b1);
    frame(1'b1);
    chk("trig2", 16'(oState), 16'd3);
    iArm = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk("disarm_held", 16'(oState), 16'd3);
    frame(1'b0);
    frame(1'b0);
    frame(1'b0);
    chk("disarm_held3", 16'(oState), 16'd3);
    frame(1'b0);
    chk("disarm_done", 16'(oHold_Done), 16'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("disarm_exit", 16'(oState), 16'd0);
    chk("disarm_video", 16'(oVideo_On), 16'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("disarm_vdrop", 16'(oVideo_On), 16'd0);

    // Disarm on the same strobe that completes detection
    arm_up();
    frame(1'b1);
    frame(1'b1);
    step(1'b0, 1'b0, 1'b0);
    iArm = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    chk("sim_state", 16'(oState), 16'd0);
    chk("sim_pulse", 16'(oAlarm_Pulse), 16'd0);
    chk("sim_video", 16'(oVideo_On), 16'd0);

    // Motion while disarmed is ignored, then reset mid-TRIGGERED
    frame(1'b1);
    arm_up();
    chk("motion_ignored", 16'(oState), 16'd2);
    frame(1'b1);
    frame(1'b1);
    frame(1'b1);
    chk("trig3_video", 16'(oVideo_On), 16'd1);
    iRST_N = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    chk("rst_mid_state", 16'(oState), 16'd0);
    chk("rst_mid_video", 16'(oVideo_On), 16'd0);
    chk("rst_mid_pulse", 16'(oAlarm_Pulse), 16'd0);
    chk("rst_mid_hold",  16'(oHold_Done), 16'd0);
    iRST_N = 1'b1;
    iArm = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk("post_rst_idle", 16'(oState), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alarm_display_ctrl.md
ALARM_DISPLAY_CTRL -- requirements
Module: alarm_display_ctrl

Interface
REQ-001 Parameter ARM_DELAY_FRAMES, default 300, exit-delay frames spent in ARMING before ARMED (range 1..65535).
REQ-002 Parameter DETECT_FRAMES, default 3, consecutive motion frames required to trigger (range 1..65535).
REQ-003 Parameter HOLD_FRAMES, default 600, minimum frames the alarm display is held (range 1..65535).
REQ-004 iCLK  input  1  pixel clock; all logic on rising edge; one clock domain.
REQ-005 iRST_N  input  1  synchronous, active-low reset.
REQ-006 iFrame_Strobe  input  1  one-cycle pulse at start of each VGA frame.
REQ-007 iArm  input  1  level; 1 = system armed request, 0 = disarm request.
REQ-008 iMotion  input  1  motion-detect indication, may pulse on any cycle.
REQ-009 iAck  input  1  one-cycle alarm acknowledge.
REQ-010 oVideo_On  output  1  registered; drives overlay select (1 = video feed + "INTRUDER", 0 = "ARMED" screen).
REQ-011 oState  output  2  current state encoding: 0 DISARMED, 1 ARMING, 2 ARMED, 3 TRIGGERED.
REQ-012 oAlarm_Pulse  output  1  one-cycle pulse on the cycle the state enters TRIGGERED.
REQ-013 oHold_Done  output  1  1 while in TRIGGERED and hold counter has reached HOLD_FRAMES.

Function
REQ-014 Block SHALL implement a 4-state FSM (DISARMED, ARMING, ARMED, TRIGGERED) with registered state.
REQ-015 DISARMED: iArm=1 SHALL move to ARMING next cycle, arm counter cleared to 0.
REQ-016 ARMING: each iFrame_Strobe SHALL increment arm counter; strobe when counter = ARM_DELAY_FRAMES-1 SHALL move to ARMED; iArm=0 on any cycle SHALL move to DISARMED (priority over strobe).
REQ-017 A motion latch SHALL set on any cycle with iMotion=1 and clear on every iFrame_Strobe cycle; frame sample = latch OR iMotion on the strobe cycle.
REQ-018 ARMED: on each strobe, frame sample=1 SHALL increment motion counter, sample=0 SHALL clear it; strobe with sample=1 and counter = DETECT_FRAMES-1 SHALL move to TRIGGERED.
REQ-019 ARMED: iArm=0 SHALL move to DISARMED next cycle, overriding a simultaneous trigger.
REQ-020 Motion counter SHALL clear on every entry to ARMED and in all non-ARMED states; motion outside ARMED SHALL be ignored.
REQ-021 TRIGGERED: hold counter cleared on entry; incremented on each strobe; SHALL saturate at HOLD_FRAMES (16-bit, no wrap).
REQ-022 TRIGGERED exit SHALL occur only when oHold_Done=1 and (iAck=1 or iArm=0); destination ARMED if iArm=1, else DISARMED.
REQ-023 iAck or iArm=0 while oHold_Done=0 SHALL be ignored (not remembered).
REQ-024 oVideo_On SHALL change only on iFrame_Strobe cycles, loading (next state == TRIGGERED); between strobes it SHALL hold.
REQ-025 Consequence: entry to TRIGGERED (always on a strobe) raises oVideo_On on the same clock edge; exit from TRIGGERED lowers oVideo_On at the next strobe edge.
REQ-026 oState SHALL reflect the state register with zero additional latency.
REQ-027 iAck outside TRIGGERED SHALL have no effect.
REQ-028 All counters SHALL be 16 bits and never wrap.

Reset
REQ-029 iRST_N=0 on a rising edge SHALL force: state DISARMED, all counters 0, motion latch 0, oVideo_On 0, oAlarm_Pulse 0, oHold_Done 0, oState 0.
REQ-030 Reset SHALL take priority over all inputs, including mid-TRIGGERED and on a strobe cycle; first state change after release requires a new iArm=1 evaluation.

Verification (ARM_DELAY_FRAMES=2, DETECT_FRAMES=3, HOLD_FRAMES=4)
REQ-031 Arm: iArm=1 from reset -> oState 1, after 2nd strobe oState 2; oVideo_On stays 0.
REQ-032 Trigger: ARMED, motion in 3 consecutive frames -> oState 3 and oVideo_On 1 at 3rd strobe edge, oAlarm_Pulse high exactly 1 cycle; motion in frames 1,2, none in 3, then 1 -> no trigger until 3 more consecutive.
REQ-033 Hold: TRIGGERED, iAck after 2 strobes -> ignored; iAck after 4th strobe (oHold_Done=1) -> oState 2 next cycle, oVideo_On 0 at next strobe.
REQ-034 Disarm: iArm=0 during ARMING -> oState 0 next cycle; iArm=0 during TRIGGERED -> stays 3 until hold done, then oState 0.
REQ-035 Simultaneous: strobe completing 3rd motion frame with iArm=0 same cycle -> oState 0, oAlarm_Pulse 0, oVideo_On 0.
REQ-036 Reset mid-TRIGGERED (oVideo_On=1) -> next edge all outputs 0, oState 0.
